control_logic: RTL and testbench



---
 rtl/control_logic_if.sv | 35 +++
 rtl/control_logic.sv | 130 +++++++++++++
 tb/tb_control_logic.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_logic_if.sv
// Control/datapath bundle for the RSA sequencer: datapath flags in, state and strobes out.
// D3..D0 state-code outputs exist only when CTRL_STATE_CODE_EN is defined.
interface control_logic_if;
  logic        init;
  logic        e;
  logic        d;
  logic        En;
  logic        De;
  logic        H1, H4, H6, H8, H9, H12, H13, H14, H15;
  logic [15:0] current_state;
  logic        load, mul, dec, gcd, cmp, mod, pow, out, sel, inc;
`ifdef CTRL_STATE_CODE_EN
  logic        D3, D2, D1, D0;
`endif

  modport master (
    output init, e, d, En, De,
    output H1, H4, H6, H8, H9, H12, H13, H14, H15,
`ifdef CTRL_STATE_CODE_EN
    input  D3, D2, D1, D0,
`endif
    input  current_state,
    input  load, mul, dec, gcd, cmp, mod, pow, out, sel, inc
  );

  modport slave (
    input  init, e, d, En, De,
    input  H1, H4, H6, H8, H9, H12, H13, H14, H15,
`ifdef CTRL_STATE_CODE_EN
    output D3, D2, D1, D0,
`endif
    output current_state,
    output load, mul, dec, gcd, cmp, mod, pow, out, sel, inc
  );
endinterface

// File: rtl/control_logic.sv
// Moore sequencer for the 4-bit RSA datapath: key generation, then encrypt/decrypt and output.
// One-hot state register; CTRL_STATE_CODE_EN adds the binary state index on D3..D0.
module control_logic (
  input  logic           clk,
  input  logic           reset,
  control_logic_if.slave bus
);

  typedef enum logic [15:0] {
    S0  = 16'h0001,  // IDLE
    S1  = 16'h0002,  // LOAD
    S2  = 16'h0004,  // MUL_N
    S3  = 16'h0008,  // DEC_PHI
    S4  = 16'h0010,  // GCD
    S5  = 16'h0020,  // CMP_E
    S6  = 16'h0040,  // SEL_E
    S7  = 16'h0080,  // INC_E
    S8  = 16'h0100,  // MUL_D
    S9  = 16'h0200,  // MOD_D
    S10 = 16'h0400,  // CMP_D
    S11 = 16'h0800,  // INC_D
    S12 = 16'h1000,  // READY
    S13 = 16'h2000,  // ENC
    S14 = 16'h4000,  // DECR
    S15 = 16'h8000   // OUT
  } state_e;

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Anything that is not exactly one-hot falls into default and recovers to IDLE.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = bus.init ? S1 : S0;
      S1:      state_d = bus.H1 ? S2 : S1;
      S2:      state_d = S3;
      S3:      state_d = S4;
      S4:      state_d = bus.H4 ? S5 : S4;
      S5:      state_d = bus.e ? S6 : S7;
      S6:      state_d = bus.H6 ? S8 : S6;
      S7:      state_d = S4;
      S8:      state_d = bus.H8 ? S9 : S8;
      S9:      state_d = bus.H9 ? S10 : S9;
      S10:     state_d = bus.d ? S12 : S11;
      S11:     state_d = S8;
      S12: begin
        if (bus.H12 && bus.En) begin
          state_d = S13;
        end else if (bus.H12 && bus.De) begin
          state_d = S14;
        end else begin
          state_d = S12;
        end
      end
      S13:     state_d = bus.H13 ? S15 : S13;
      S14:     state_d = bus.H14 ? S15 : S14;
      S15:     state_d = bus.H15 ? S0 : S15;
      default: state_d = S0;
    endcase
  end

  always_comb begin
    bus.load = 1'b0;
    bus.mul  = 1'b0;
    bus.dec  = 1'b0;
    bus.gcd  = 1'b0;
    bus.cmp  = 1'b0;
    bus.mod  = 1'b0;
    bus.pow  = 1'b0;
    bus.out  = 1'b0;
    bus.sel  = 1'b0;
    bus.inc  = 1'b0;
    case (state_q)
      S1:  bus.load = 1'b1;
      S2:  bus.mul  = 1'b1;
      S3:  bus.dec  = 1'b1;
      S4:  bus.gcd  = 1'b1;
      S5:  bus.cmp  = 1'b1;
      S6:  bus.sel  = 1'b1;
      S7:  bus.inc  = 1'b1;
      S8: begin
        bus.mul = 1'b1;
        bus.sel = 1'b1;
      end
      S9:  bus.mod  = 1'b1;
      S10: bus.cmp  = 1'b1;
      S11: begin
        bus.inc = 1'b1;
        bus.sel = 1'b1;
      end
      S13: bus.pow  = 1'b1;
      S14: begin
        bus.pow = 1'b1;
        bus.sel = 1'b1;
      end
      S15: bus.out  = 1'b1;
      default: ;
    endcase
  end

  assign bus.current_state = state_q;

`ifdef CTRL_STATE_CODE_EN
  logic [3:0] code;

  always_comb begin
    code = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (state_q == (16'h0001 << k)) begin
        code = k[3:0];
      end
    end
  end

  assign bus.D3 = code[3];
  assign bus.D2 = code[2];
  assign bus.D1 = code[1];
  assign bus.D0 = code[0];
`endif

endmodule

// File: tb/tb_control_logic.sv
// Directed bench for control_logic: walks key generation, retry loops, encrypt/decrypt,
// stalls, asynchronous reset and illegal-state recovery against hand-computed values.
module tb_control_logic;

  logic clk;
  logic reset;

  control_logic_if bus ();

  control_logic dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [9:0] LOAD = 10'h200;
  localparam logic [9:0] MUL  = 10'h100;
  localparam logic [9:0] DEC  = 10'h080;
  localparam logic [9:0] GCD  = 10'h040;
  localparam logic [9:0] CMP  = 10'h020;
  localparam logic [9:0] MOD  = 10'h010;
  localparam logic [9:0] POW  = 10'h008;
  localparam logic [9:0] OUT  = 10'h004;
  localparam logic [9:0] SEL  = 10'h002;
  localparam logic [9:0] INC  = 10'h001;
  localparam logic [9:0] NONE = 10'h000;

  int checks;
  int errors;

  logic [9:0] strb;
  assign strb = {bus.load, bus.mul, bus.dec, bus.gcd, bus.cmp,
                 bus.mod, bus.pow, bus.out, bus.sel, bus.inc};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [15:0] st, input logic [9:0] sb);
    check({tag, "_state"}, {16'h0, bus.current_state}, {16'h0, st});
    check({tag, "_strb"}, {22'h0, strb}, {22'h0, sb});
  endtask

  task automatic clear_inputs();
    bus.init = 1'b0; bus.e = 1'b0; bus.d = 1'b0; bus.En = 1'b0; bus.De = 1'b0;
    bus.H1 = 1'b0; bus.H4 = 1'b0; bus.H6 = 1'b0; bus.H8 = 1'b0; bus.H9 = 1'b0;
    bus.H12 = 1'b0; bus.H13 = 1'b0; bus.H14 = 1'b0; bus.H15 = 1'b0;
  endtask

  // From S0, with every key-gen flag high, one state per cycle to READY.
  task automatic run_keygen();
    int path [9] = '{2, 3, 4, 5, 6, 8, 9, 10, 12};
    logic [15:0] exp_st;
    clear_inputs();
    bus.init = 1'b1;
    bus.H1 = 1'b1; bus.H4 = 1'b1; bus.H6 = 1'b1; bus.H8 = 1'b1; bus.H9 = 1'b1;
    bus.e = 1'b1; bus.d = 1'b1;
    tick();
    check("kg_s1", {16'h0, bus.current_state}, 32'h0002);
    bus.init = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_st = 16'h0001 << path[i];
      check("kg_path", {16'h0, bus.current_state}, {16'h0, exp_st});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b0;
    bus.init = 1'b1;
    tick();
    tick();
    chk_st("rst", 16'h0001, NONE);
`ifdef CTRL_STATE_CODE_EN
    check("rst_code", {28'h0, bus.D3, bus.D2, bus.D1, bus.D0}, 32'h0);
`endif

    reset = 1'b1;
    tick();
    chk_st("s1", 16'h0002, LOAD);
    bus.init = 1'b0;
    tick();
    chk_st("s1_hold", 16'h0002, LOAD);

    bus.H1 = 1'b1;
    tick();
    chk_st("s2", 16'h0004, MUL);
    bus.H1 = 1'b0;
    tick();
    chk_st("s3", 16'h0008, DEC);
    bus.En = 1'b1;
    tick();
    chk_st("s4", 16'h0010, GCD);
    tick();
    chk_st("s4_hold", 16'h0010, GCD);
    bus.En = 1'b0;

    bus.H4 = 1'b1;
    bus.e  = 1'b0;
    tick();
    chk_st("s5", 16'h0020, CMP);
    tick();
    chk_st("s7", 16'h0080, INC);
    tick();
    chk_st("s7_s4", 16'h0010, GCD);
    tick();
    chk_st("s5_again", 16'h0020, CMP);
    bus.e = 1'b1;
    tick();
    chk_st("s6", 16'h0040, SEL);
    bus.H4 = 1'b0;
    bus.H6 = 1'b1;
    tick();
    chk_st("s8", 16'h0100, MUL | SEL);
    bus.H6 = 1'b0;
    bus.H8 = 1'b1;
    tick();
    chk_st("s9", 16'h0200, MOD);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s9_stall", {16'h0, bus.current_state}, 32'h0200);
    end
    bus.H9 = 1'b1;
    tick();
    chk_st("s10", 16'h0400, CMP);
`ifdef CTRL_STATE_CODE_EN
    check("s10_code", {28'h0, bus.D3, bus.D2, bus.D1, bus.D0}, 32'ha);
`endif
    bus.d = 1'b0;
    tick();
    chk_st("s11", 16'h0800, INC | SEL);
    tick();
    chk_st("s11_s8", 16'h0100, MUL | SEL);
    tick();
    chk_st("s9_b", 16'h0200, MOD);
    tick();
    chk_st("s10_b", 16'h0400, CMP);
    bus.d = 1'b1;
    tick();
    chk_st("s12", 16'h1000, NONE);

    bus.En = 1'b1;
    tick();
    chk_st("s12_noh", 16'h1000, NONE);
    bus.H12 = 1'b1;
    bus.De  = 1'b1;
    tick();
    chk_st("s13_prio", 16'h2000, POW);
`ifdef CTRL_STATE_CODE_EN
    check("s13_code", {28'h0, bus.D3, bus.D2, bus.D1, bus.D0}, 32'hd);
`endif
    bus.H13 = 1'b1;
    tick();
    chk_st("s15", 16'h8000, OUT);
    bus.H15 = 1'b1;
    tick();
    chk_st("s15_s0", 16'h0001, NONE);

    run_keygen();
    bus.H12 = 1'b1;
    bus.De  = 1'b1;
    tick();
    chk_st("s14", 16'h4000, POW | SEL);
    bus.H14 = 1'b1;
    tick();
    chk_st("s14_s15", 16'h8000, OUT);
    bus.H15 = 1'b1;
    tick();
    chk_st("s0_again", 16'h0001, NONE);

    run_keygen();
    bus.H12 = 1'b1;
    bus.En  = 1'b1;
    tick();
    chk_st("s13_b", 16'h2000, POW);
    #2;
    reset = 1'b0;
    #1;
    chk_st("async_rst", 16'h0001, NONE);
    clear_inputs();
    tick();
    reset = 1'b1;
    tick();
    chk_st("post_rst", 16'h0001, NONE);

    force dut.state_q = 16'h0003;
    #1;
    check("illegal_vis", {16'h0, bus.current_state}, 32'h0003);
    tick();
    release dut.state_q;
    tick();
    chk_st("illegal_rec", 16'h0001, NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
